// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg : shared I2C state encodings and bus constants (master + target)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] i2c_state_t;

  localparam i2c_state_t ST_IDLE      = 3'd0;
  localparam i2c_state_t ST_ADDR      = 3'd1;
  localparam i2c_state_t ST_ADDR_ACK  = 3'd2;
  localparam i2c_state_t ST_WR_DATA   = 3'd3;
  localparam i2c_state_t ST_WR_ACK    = 3'd4;
  localparam i2c_state_t ST_RD_DATA   = 3'd5;
  localparam i2c_state_t ST_RD_ACK    = 3'd6;
  localparam i2c_state_t ST_WAIT_STOP = 3'd7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_READ  = 1'b1;

  // General call (7'h00) is never treated as a match, whatever the own address.
  function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] own);
    return (addr == own) && (addr != 7'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync : SCL/SDA synchronizers, edge strobes, START/STOP detection
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_hist_q, scl_hist_d;
  logic sda_hist_q, sda_hist_d;
  logic scl_s;
  logic sda_rise, sda_fall;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign sda_rise  = sda_s & ~sda_hist_q;
  assign sda_fall  = ~sda_s & sda_hist_q;
  assign start_det = sda_fall & scl_s & scl_hist_q;
  assign stop_det  = sda_rise & scl_s & scl_hist_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_core.sv
// ---------------------------------------------------------------------------
// i2c_slave_core : single-address oversampling I2C target, no clock stretching
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       rw_bit,
  output logic       busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (SCL),
    .sda_in    (SDA),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_hit_q, addr_hit_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       hit;

  assign rx_byte   = {shift_q[6:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign hit       = addr_match(rx_byte[7:1], SLAVE_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  // In the ACK states sda_oe_q doubles as the phase flag: 0 = ACK not yet driven.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      unique case (state_q)
        ST_IDLE:      state_d = ST_IDLE;
        ST_ADDR:      if (byte_done) state_d = hit ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:  if (scl_fall && sda_oe_q)
                        state_d = (rw_q == RW_READ) ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA:   if (byte_done) state_d = ST_WR_ACK;
        ST_WR_ACK:    if (scl_fall && sda_oe_q) state_d = ST_WR_DATA;
        ST_RD_DATA:   if (scl_fall && bit_cnt_q == 3'd0) state_d = ST_RD_ACK;
        ST_RD_ACK:    if (scl_rise && sda_s == I2C_NACK) state_d = ST_WAIT_STOP;
                      else if (scl_fall) state_d = ST_RD_DATA;
        ST_WAIT_STOP: state_d = ST_WAIT_STOP;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    addr_hit_d = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    tx_req     = 1'b0;
    if (stop_det) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_hit_d = hit;
            busy_d     = hit;
            if (hit) rw_d = rx_byte[0];
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
            if (rw_q == RW_READ) begin
              tx_req  = 1'b1;
              shift_d = tx_data;
            end
          end else if (rw_q == RW_READ) begin
            sda_oe_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = 3'd1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
          end
        end
        ST_WR_ACK: if (scl_fall) sda_oe_d = ~sda_oe_q;
        ST_RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        // Only reachable after an ACK on the preceding rise; NACK already left.
        ST_RD_ACK: if (scl_fall) begin
          tx_req    = 1'b1;
          sda_oe_d  = ~tx_data[7];
          shift_d   = {tx_data[6:0], 1'b0};
          bit_cnt_d = 3'd1;
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign addr_hit = addr_hit_q;
  assign rw_bit   = rw_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_core.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_core : bit-banged I2C master bench for i2c_slave_core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2c_slave_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_hit, rw_bit, busy;
  wire        sda_w;

  pullup (sda_w);
  assign sda_w = m_sda ? 1'bz : 1'b0;

  i2c_slave_core #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .SCL      (scl),
    .SDA      (sda_w),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .addr_hit (addr_hit),
    .rw_bit   (rw_bit),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int hit_cnt = 0, rxv_cnt = 0, txr_cnt = 0, busy_cyc = 0, low_cyc = 0, ovl_cnt = 0;
  logic last_rw = 1'b0;

  always @(negedge clk) begin
    if (addr_hit) begin hit_cnt++; last_rw = rw_bit; end
    if (rx_valid) rxv_cnt++;
    if (tx_req) txr_cnt++;
    if (busy) busy_cyc++;
    if (m_sda && !sda_w) low_cyc++;
    if (rx_valid && tx_req) ovl_cnt++;
  end

  int n_vec = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic qtr();
    repeat (5) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; scl = 1'b1; qtr();
    m_sda = 1'b0; qtr();
    scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    qtr(); m_sda = 1'b1; qtr();
    scl = 1'b1; qtr();
    m_sda = 1'b0; qtr();
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    qtr(); m_sda = 1'b0; qtr();
    scl = 1'b1; qtr();
    m_sda = 1'b1; qtr(); qtr();
  endtask

  task automatic write_bit(input logic b);
    qtr(); m_sda = b; qtr();
    scl = 1'b1; qtr(); qtr();
    scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    qtr(); m_sda = 1'b1; qtr();
    scl = 1'b1; qtr();
    b = sda_w; qtr();
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int k = 7; k >= 0; k--) write_bit(d[k]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    for (int k = 7; k >= 0; k--) read_bit(d[k]);
    write_bit(ack);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;
    logic       exp_hit;
    logic [7:0] exp_rx;
  } wvec_t;

  wvec_t tbl[6];

  initial begin
    logic aack, dack, b;
    logic [7:0] rb0, rb1;
    int h0, r0, t0, bc0, lc0;

    tbl[0] = '{7'h50, 8'hA5, 1'b0, 1'b1, 8'hA5};
    tbl[1] = '{7'h51, 8'h3C, 1'b1, 1'b0, 8'hA5};
    tbl[2] = '{7'h50, 8'h5A, 1'b0, 1'b1, 8'h5A};
    tbl[3] = '{7'h00, 8'hFF, 1'b1, 1'b0, 8'h5A};
    tbl[4] = '{7'h28, 8'h0F, 1'b1, 1'b0, 8'h5A};
    tbl[5] = '{7'h50, 8'h00, 1'b0, 1'b1, 8'h00};

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {rx_data, rx_valid, tx_req, addr_hit, rw_bit, busy}, 32'h0);
    chk("reset_sda_released", sda_w, 1'b1);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      h0 = hit_cnt; r0 = rxv_cnt; bc0 = busy_cyc; lc0 = low_cyc;
      i2c_start();
      write_byte({tbl[i].addr, 1'b0}, aack);
      write_byte(tbl[i].data, dack);
      i2c_stop();
      @(negedge clk);
      chk($sformatf("v%0d_addr_ack", i), aack, tbl[i].exp_ack);
      chk($sformatf("v%0d_data_ack", i), dack, tbl[i].exp_ack);
      chk($sformatf("v%0d_addr_hit", i), hit_cnt - h0, tbl[i].exp_hit);
      chk($sformatf("v%0d_rx_valid", i), rxv_cnt - r0, tbl[i].exp_hit);
      chk($sformatf("v%0d_rx_data", i), rx_data, tbl[i].exp_rx);
      chk($sformatf("v%0d_busy_seen", i), busy_cyc > bc0, tbl[i].exp_hit);
      chk($sformatf("v%0d_sda_driven", i), low_cyc > lc0, tbl[i].exp_hit);
      chk($sformatf("v%0d_busy_after_stop", i), busy, 1'b0);
      if (tbl[i].exp_hit) chk($sformatf("v%0d_rw_bit", i), rw_bit, 1'b0);
    end

    // Read two bytes: ACK the first, NACK the second.
    h0 = hit_cnt; t0 = txr_cnt; r0 = rxv_cnt;
    tx_data = 8'h3C;
    i2c_start();
    write_byte({7'h50, 1'b1}, aack);
    tx_data = 8'hC3;
    read_byte(rb0, 1'b0);
    read_byte(rb1, 1'b1);
    i2c_stop();
    @(negedge clk);
    chk("rd_addr_ack", aack, 1'b0);
    chk("rd_byte0", rb0, 8'h3C);
    chk("rd_byte1", rb1, 8'hC3);
    chk("rd_tx_req_pulses", txr_cnt - t0, 2);
    chk("rd_addr_hit", hit_cnt - h0, 1);
    chk("rd_rw_latched", last_rw, 1'b1);
    chk("rd_no_rx_valid", rxv_cnt - r0, 0);
    chk("rd_busy_after_stop", busy, 1'b0);

    // Write, repeated START, read.
    h0 = hit_cnt;
    tx_data = 8'hFF;
    i2c_start();
    write_byte({7'h50, 1'b0}, aack);
    write_byte(8'h11, dack);
    i2c_rstart();
    write_byte({7'h50, 1'b1}, b);
    read_byte(rb0, 1'b1);
    @(negedge clk);
    chk("rs_rw_bit", rw_bit, 1'b1);
    i2c_stop();
    @(negedge clk);
    chk("rs_acks", {aack, dack, b}, 3'b000);
    chk("rs_rx_data", rx_data, 8'h11);
    chk("rs_addr_hits", hit_cnt - h0, 2);
    chk("rs_read_byte", rb0, 8'hFF);

    // Reset while the target holds the address ACK low.
    h0 = hit_cnt;
    i2c_start();
    for (int k = 7; k >= 0; k--) write_bit(k == 0 ? 1'b0 : (7'h50 >> (k - 1)) & 1'b1);
    qtr(); m_sda = 1'b1; qtr();
    @(negedge clk);
    chk("rst_ack_driven", sda_w, 1'b0);
    chk("rst_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_sda_released", sda_w, 1'b1);
    chk("rst_outputs_zero", {rx_data, rx_valid, tx_req, addr_hit, rw_bit, busy}, 32'h0);
    repeat (3) @(posedge clk);
    reset = 1'b0;
    scl = 1'b1; qtr(); qtr();
    r0 = rxv_cnt;
    i2c_start();
    write_byte({7'h50, 1'b0}, aack);
    write_byte(8'h77, dack);
    i2c_stop();
    @(negedge clk);
    chk("rst_next_acks", {aack, dack}, 2'b00);
    chk("rst_next_rx", rx_data, 8'h77);
    chk("rst_next_rx_valid", rxv_cnt - r0, 1);

    // STOP after only four data bits.
    r0 = rxv_cnt; h0 = hit_cnt;
    i2c_start();
    write_byte({7'h50, 1'b0}, aack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    @(negedge clk);
    chk("stop4_addr_ack", aack, 1'b0);
    chk("stop4_no_rx_valid", rxv_cnt - r0, 0);
    chk("stop4_busy", busy, 1'b0);
    chk("stop4_sda_released", sda_w, 1'b1);
    chk("stop4_rx_kept", rx_data, 8'h77);

    chk("no_rxv_txreq_overlap", ovl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
